// File: rtl/register_file_pkg.sv
// register_file_pkg: shared sizes, register-address type and zero-register constant for the register file.
// Contents: REG_COUNT, DATA_WIDTH, ADDR_WIDTH, reg_addr_t, ZERO_REG.
package pack;
    localparam int REG_COUNT  = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = $clog2(REG_COUNT);
    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    localparam reg_addr_t ZERO_REG = '0;
endpackage

// File: rtl/register_file_scoreboard.sv
// register_scoreboard: per-register busy bits tracking in-flight producers, and the decode stall.
// Ports: clock, reset (async active-low), issue_enable/issue_register (set busy),
//        commit_enable/commit_register (clear busy), flush (clear all), read_a/read_b (sources),
//        stall (a source is still pending).
// Macro REGFILE_BYPASS_EN: a source committing this cycle does not stall.
module register_scoreboard #(
    parameter int REG_COUNT = pack::REG_COUNT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       issue_enable,
    input  logic [pack::ADDR_WIDTH-1:0] issue_register,
    input  logic                       commit_enable,
    input  logic [pack::ADDR_WIDTH-1:0] commit_register,
    input  logic                       flush,
    input  logic [pack::ADDR_WIDTH-1:0] read_a,
    input  logic [pack::ADDR_WIDTH-1:0] read_b,
    output logic                       stall
);
    import pack::*;
    logic [REG_COUNT-1:0] busy, busy_next, set_mask, clear_mask;
    logic hit_a, hit_b;
    // Set is applied after clear so a newer producer issued on the commit edge stays outstanding.
    always_comb begin
        set_mask = '0;
        clear_mask = '0;
        if (issue_enable)
            set_mask[issue_register] = 1'b1;
        if (commit_enable)
            clear_mask[commit_register] = 1'b1;
        busy_next = flush ? '0 : ((busy & ~clear_mask) | set_mask);
        busy_next[0] = 1'b0;
    end
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            busy <= '0;
        else
            busy <= busy_next;
`ifdef REGFILE_BYPASS_EN
    assign hit_a = commit_enable && commit_register != ZERO_REG && commit_register == read_a;
    assign hit_b = commit_enable && commit_register != ZERO_REG && commit_register == read_b;
`else
    assign hit_a = 1'b0;
    assign hit_b = 1'b0;
`endif
    // Depends only on registered busy state and commit inputs, never on issue_enable.
    assign stall = (busy[read_a] && !hit_a) || (busy[read_b] && !hit_b);
endmodule

// File: rtl/register_file.sv
// register_file: two-read/one-write register file with x0 hardwired to zero and a busy-bit scoreboard.
// Ports: clock, reset (async active-low), destinationEnable/writeAddress/writeData (commit),
//        readAddressA/B -> readDataA/B (combinational), issueEnable/issueRegister (mark busy),
//        flush (drop all in-flight producers), stall (source operand pending).
// Macro REGFILE_BYPASS_EN: same-cycle commit data is forwarded to matching read ports.
module register_file #(
    parameter int DATA_WIDTH = pack::DATA_WIDTH,
    parameter int REG_COUNT  = pack::REG_COUNT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        destinationEnable,
    input  logic [pack::ADDR_WIDTH-1:0] writeAddress,
    input  logic [DATA_WIDTH-1:0]       writeData,
    input  logic [pack::ADDR_WIDTH-1:0] readAddressA,
    input  logic [pack::ADDR_WIDTH-1:0] readAddressB,
    output logic [DATA_WIDTH-1:0]       readDataA,
    output logic [DATA_WIDTH-1:0]       readDataB,
    input  logic                        issueEnable,
    input  logic [pack::ADDR_WIDTH-1:0] issueRegister,
    input  logic                        flush,
    output logic                        stall
);
    import pack::*;
    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs;
    logic commit, byp_a, byp_b;
    assign commit = destinationEnable && writeAddress != ZERO_REG;
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            regs <= '0;
        else if (commit)
            regs[writeAddress] <= writeData;
`ifdef REGFILE_BYPASS_EN
    assign byp_a = commit && writeAddress == readAddressA;
    assign byp_b = commit && writeAddress == readAddressB;
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
`endif
    assign readDataA = (readAddressA == ZERO_REG) ? '0 : byp_a ? writeData : regs[readAddressA];
    assign readDataB = (readAddressB == ZERO_REG) ? '0 : byp_b ? writeData : regs[readAddressB];
    register_scoreboard #(.REG_COUNT(REG_COUNT)) u_scoreboard (
        .clock(clock),
        .reset(reset),
        .issue_enable(issueEnable),
        .issue_register(issueRegister),
        .commit_enable(destinationEnable),
        .commit_register(writeAddress),
        .flush(flush),
        .read_a(readAddressA),
        .read_b(readAddressB),
        .stall(stall)
    );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: table-driven directed checks of the register file plus hand-written reset sequence.
module tb_register_file;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        destinationEnable = 1'b0;
    logic [4:0]  writeAddress = '0;
    logic [31:0] writeData = '0;
    logic [4:0]  readAddressA = '0;
    logic [4:0]  readAddressB = '0;
    logic [31:0] readDataA, readDataB;
    logic        issueEnable = 1'b0;
    logic [4:0]  issueRegister = '0;
    logic        flush = 1'b0;
    logic        stall;
    int checks = 0;
    int failures = 0;

    register_file dut (
        .clock(clock), .reset(reset),
        .destinationEnable(destinationEnable), .writeAddress(writeAddress), .writeData(writeData),
        .readAddressA(readAddressA), .readAddressB(readAddressB),
        .readDataA(readDataA), .readDataB(readDataB),
        .issueEnable(issueEnable), .issueRegister(issueRegister),
        .flush(flush), .stall(stall)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        de;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic        ie;
        logic [4:0]  ir;
        logic        fl;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_s;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic de, logic [4:0] wa, logic [31:0] wd, logic [4:0] ra, logic [4:0] rb,
                                logic ie, logic [4:0] ir, logic fl,
                                logic [31:0] exp_a, logic [31:0] exp_b, logic exp_s);
        vec_t v;
        v.de = de; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb;
        v.ie = ie; v.ir = ir; v.fl = fl;
        v.exp_a = exp_a; v.exp_b = exp_b; v.exp_s = exp_s;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        destinationEnable = 1'b0; writeAddress = '0; writeData = '0;
        issueEnable = 1'b0; issueRegister = '0; flush = 1'b0;
    endtask

    initial begin
        // Inputs change on the falling edge; outputs are sampled 1 ns later, before the next rising edge.
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk(1, 1, 32'h11111111, 1, 2, 0, 0, 0, BYP ? 32'h11111111 : 32'h0, 32'h0, 0));
        tbl.push_back(mk(1, 2, 32'h22222222, 1, 2, 0, 0, 0, 32'h11111111, BYP ? 32'h22222222 : 32'h0, 0));
        tbl.push_back(mk(1, 0, 32'h12345678, 0, 1, 0, 0, 0, 32'h0, 32'h11111111, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 2, 1, 0, 0, 32'h0, 32'h22222222, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 7, 0, 1, 7, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 7, 0, 0, 0, 0, 32'h0, 32'h0, 1));
        tbl.push_back(mk(1, 7, 32'h0000ABCD, 7, 0, 0, 0, 0, BYP ? 32'h0000ABCD : 32'h0, 32'h0, !BYP));
        tbl.push_back(mk(0, 0, 32'h0, 7, 0, 0, 0, 0, 32'h0000ABCD, 32'h0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 9, 0, 1, 9, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk(1, 9, 32'h55, 9, 9, 1, 9, 0, BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0, !BYP));
        tbl.push_back(mk(0, 0, 32'h0, 9, 0, 0, 0, 0, 32'h55, 32'h0, 1));
        tbl.push_back(mk(1, 9, 32'h66, 0, 0, 0, 0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 9, 0, 0, 0, 0, 32'h66, 32'h0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 1, 3, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 3, 0, 1, 4, 0, 32'h0, 32'h0, 1));
        tbl.push_back(mk(1, 3, 32'h33, 3, 4, 1, 6, 1, BYP ? 32'h33 : 32'h0, 32'h0, 1));
        tbl.push_back(mk(0, 0, 32'h0, 3, 4, 0, 0, 0, 32'h33, 32'h0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 6, 6, 0, 0, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk(1, 10, 32'hCAFEF00D, 0, 10, 0, 0, 0, 32'h0, BYP ? 32'hCAFEF00D : 32'h0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 10, 0, 0, 0, 32'h0, 32'hCAFEF00D, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 0, 1, 12, 0, 32'h0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 32'h0, 0, 12, 0, 0, 0, 32'h0, 32'h0, 1));
        tbl.push_back(mk(1, 12, 32'h1, 12, 12, 0, 0, 0, BYP ? 32'h1 : 32'h0, BYP ? 32'h1 : 32'h0, !BYP));
        tbl.push_back(mk(0, 0, 32'h0, 12, 12, 0, 0, 0, 32'h1, 32'h1, 0));

        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            destinationEnable = tbl[i].de; writeAddress = tbl[i].wa; writeData = tbl[i].wd;
            readAddressA = tbl[i].ra; readAddressB = tbl[i].rb;
            issueEnable = tbl[i].ie; issueRegister = tbl[i].ir; flush = tbl[i].fl;
            #1;
            check($sformatf("vec%0d readDataA", i), readDataA, tbl[i].exp_a);
            check($sformatf("vec%0d readDataB", i), readDataB, tbl[i].exp_b);
            check($sformatf("vec%0d stall", i), {31'b0, stall}, {31'b0, tbl[i].exp_s});
        end

        // Reset mid-run: x5 written and x8 busy, then reset asserted between edges.
        @(negedge clock);
        idle(); destinationEnable = 1'b1; writeAddress = 5'd5; writeData = 32'hDEADBEEF;
        @(negedge clock);
        idle(); issueEnable = 1'b1; issueRegister = 5'd8;
        readAddressA = 5'd5; readAddressB = 5'd8;
        #1;
        check("pre_reset x5", readDataA, 32'hDEADBEEF);
        @(negedge clock);
        idle();
        #1;
        check("pre_reset stall x8", {31'b0, stall}, 32'h1);
        #2;
        reset = 1'b0;
        #1;
        check("reset x5 cleared", readDataA, 32'h0);
        check("reset stall cleared", {31'b0, stall}, 32'h0);
        destinationEnable = 1'b1; writeAddress = 5'd5; writeData = 32'h77777777;
        issueEnable = 1'b1; issueRegister = 5'd5;
        @(negedge clock);
        @(negedge clock);
        #1;
        check("reset holds x5 under clock", readDataA, 32'h0);
        check("reset holds stall under clock", {31'b0, stall}, 32'h0);
        idle();
        #1;
        reset = 1'b1;
        #1;
        check("post_reset x5", readDataA, 32'h0);
        check("post_reset stall", {31'b0, stall}, 32'h0);
        @(negedge clock);
        destinationEnable = 1'b1; writeAddress = 5'd5; writeData = 32'h0BADF00D;
        @(negedge clock);
        idle();
        #1;
        check("post_reset write x5", readDataA, 32'h0BADF00D);
        check("post_reset x8 not busy", {31'b0, stall}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: register width in bits.
REQ-002 SHALL have parameter REG_COUNT, default 32: architectural registers; address width is log2(REG_COUNT) = 5.
REQ-003 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port destinationEnable  input  1  commit write from the writeback stage.
REQ-006 SHALL have port writeAddress  input  5  destination register of the commit.
REQ-007 SHALL have port writeData  input  32  commit data.
REQ-008 SHALL have ports readAddressA/readAddressB  input  5 each  decode-stage source registers.
REQ-009 SHALL have ports readDataA/readDataB  output  32 each  combinational read data.
REQ-010 SHALL have port issueEnable  input  1  instruction with a destination leaves decode this cycle.
REQ-011 SHALL have port issueRegister  input  5  destination of the issuing instruction.
REQ-012 SHALL have port flush  input  1  pipeline squash; discards all in-flight producers.
REQ-013 SHALL have port stall  output  1  a source operand is still pending.

Function
REQ-014 Storage SHALL be REG_COUNT x DATA_WIDTH flops, written on the rising clock edge when destinationEnable=1 and writeAddress!=0.
REQ-015 Register x0 SHALL always read 0; writes to x0 SHALL be discarded and SHALL NOT affect busy state.
REQ-016 Reads SHALL be combinational: readDataX = reg[readAddressX], subject to REQ-015 and REQ-027.
REQ-017 A busy bit per register (x0 excluded, always 0) SHALL form the scoreboard.
REQ-018 On an edge with issueEnable=1 and issueRegister!=0, busy[issueRegister] SHALL become 1.
REQ-019 On an edge with destinationEnable=1 and writeAddress!=0, busy[writeAddress] SHALL become 0.
REQ-020 Set and clear of the same register on the same edge: set SHALL win (newer producer outstanding).
REQ-021 flush=1 on an edge SHALL clear all busy bits and override any same-cycle issue set; the same-cycle commit write to storage SHALL still occur.
REQ-022 stall SHALL be combinational: (busy[readAddressA] or busy[readAddressB]), excluding any register that is committing this cycle when bypass is enabled (REQ-027).
REQ-023 stall SHALL NOT depend on issueEnable in the same cycle (no combinational loop through decode).
REQ-024 Write latency: data committed at edge N SHALL be visible on read ports in cycle N+1 without bypass.

Reset
REQ-025 While reset=0, all registers SHALL read 0, all busy bits SHALL be 0 and stall SHALL be 0, independent of clock.
REQ-026 Reset deasserting mid-operation SHALL leave no partial state: the first edge after deassertion SHALL behave as on a cleared file.

Configuration
REQ-027 With macro REGFILE_BYPASS_EN defined: if destinationEnable=1, writeAddress!=0 and writeAddress==readAddressX, readDataX SHALL equal writeData in the same cycle, and that register SHALL not contribute to stall; without it, readDataX SHALL show the old value and stall SHALL reflect the still-set busy bit for that cycle.

Structure
REQ-028 Package pack SHALL hold REG_COUNT, DATA_WIDTH, the register-address typedef and the zero-register constant.
REQ-029 The busy-bit logic (REQ-017 to REQ-023) SHALL be a sub-module named register_scoreboard; storage and read muxing SHALL stay in register_file.

Verification
REQ-030 Reset: drive reset=0 mid-run after writing x5=0xDEADBEEF -> readDataA(x5)=0, stall=0 immediately.
REQ-031 x0: commit 0x12345678 to x0, read x0 -> 0x00000000; issue x0 -> stall remains 0.
REQ-032 Scoreboard: issue x7, next cycle readAddressA=7 -> stall=1; commit x7=0x0000ABCD -> stall clears (same cycle with bypass, next cycle without) and readDataA=0x0000ABCD.
REQ-033 Same-edge set/clear: x9 busy, issue x9 and commit x9=0x55 on the same edge -> busy[x9] remains 1, reg x9=0x55.
REQ-034 Flush: issue x3 and x4, assert flush with issue x6 -> all busy 0, reads of x3/x4/x6 give stall=0.
REQ-035 Bypass: with REGFILE_BYPASS_EN, commit x10=0xCAFEF00D while readAddressB=10 -> readDataB=0xCAFEF00D that cycle; without it -> old value, new value next cycle.
